// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage constants and fetch FSM state type
package riscv_pkg;
  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic {S_REQ, S_HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between fetch and memory
interface fetch_stage_if;
  import riscv_pkg::*;
  logic req;
  logic [XLEN-1:0] addr;
  logic ready;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rdata);
  modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load and bubble-flush
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic valid_q, valid_d;
  always_comb begin
    pc_d = (load | flush) ? pc_in : pc_q;
    instr_d = flush ? NOP_INSTR : load ? instr_in : instr_q;
    valid_d = flush ? 1'b0 : load ? 1'b1 : valid_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
  assign if_id_pc = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fetch FSM and response buffer; FETCH_STALL_CNT_EN adds stall_count
module fetch_stage
  import riscv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            pc_load,
  input  logic            if_id_load,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]     stall_count
`endif
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d, ld_instr;
  logic accept, resp, ld, flush;
  always_comb begin
    accept = pc_load & if_id_load;
    resp = (state_q == S_REQ) & imem.ready;
    state_d = state_q;
    pc_d = pc_q;
    buf_d = buf_q;
    ld = 1'b0;
    flush = 1'b0;
    ld_instr = (state_q == S_HOLD) ? buf_q : imem.rdata;
    if (branch_taken) begin
      state_d = S_REQ;
      pc_d = branch_target & ~XLEN'(3);
      buf_d = '0;
      flush = 1'b1;
    end else if (state_q == S_HOLD || resp) begin
      ld = accept;
      pc_d = accept ? pc_q + XLEN'(4) : pc_q;
      state_d = accept ? S_REQ : S_HOLD;
      buf_d = (state_q == S_REQ && !accept) ? imem.rdata : buf_q;
    end else begin
      flush = if_id_load;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      buf_q <= buf_d;
    end
  end
  assign imem.req = (state_q == S_REQ);
  assign imem.addr = pc_q;
  if_id_reg u_if_id (
    .clock      (clock),
    .reset      (reset),
    .load       (ld),
    .flush      (flush),
    .pc_in      (pc_q),
    .instr_in   (ld_instr),
    .if_id_pc   (if_id_pc),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid)
  );
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb
    cnt_d = ((((state_q == S_REQ) & ~imem.ready) | (state_q == S_HOLD)) && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign stall_count = cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a transaction-level model
module tb_fetch_stage;
  import riscv_pkg::*;
  logic clock = 1'b0;
  logic reset, pc_load, if_id_load, branch_taken;
  logic [63:0] branch_target, if_id_pc;
  logic [31:0] if_id_instr;
  logic if_id_valid;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_count;
`endif
  fetch_stage_if imem();
  fetch_stage dut (
    .clock        (clock),
    .reset        (reset),
    .pc_load      (pc_load),
    .if_id_load   (if_id_load),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem         (imem),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );
  always #5 clock = ~clock;
  int tests = 0;
  int fails = 0;
  logic m_known = 1'b0;
  logic [63:0] m_pc, m_ipc;
  logic m_hold, m_valid;
  logic [31:0] m_buf, m_instr, m_cnt;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic r, bt, input logic [63:0] tgt, input logic pl, il, rdy, input logic [31:0] rd);
    if (r) begin
      m_pc = 0; m_hold = 0; m_buf = 0; m_ipc = 0; m_instr = NOP_INSTR; m_valid = 0; m_cnt = 0;
    end else begin
      if ((m_hold || !rdy) && m_cnt != 32'hFFFFFFFF) m_cnt++;
      if (bt) begin
        m_ipc = m_pc; m_instr = NOP_INSTR; m_valid = 0; m_pc = tgt & ~64'd3; m_hold = 0; m_buf = 0;
      end else if (m_hold) begin
        if (pl && il) begin m_ipc = m_pc; m_instr = m_buf; m_valid = 1; m_pc += 4; m_hold = 0; end
      end else if (rdy) begin
        if (pl && il) begin m_ipc = m_pc; m_instr = rd; m_valid = 1; m_pc += 4; end
        else begin m_buf = rd; m_hold = 1; end
      end else if (il) begin
        m_ipc = m_pc; m_instr = NOP_INSTR; m_valid = 0;
      end
    end
  endtask
  task automatic step(input logic r, bt, input logic [63:0] tgt, input logic pl, il, rdy, input logic [31:0] rd);
    reset = r; branch_taken = bt; branch_target = tgt;
    pc_load = pl; if_id_load = il; imem.ready = rdy; imem.rdata = rd;
    #1;
    if (m_known) begin
      check("imem_addr", imem.addr, m_pc);
      check("imem_req", 64'(imem.req), 64'(!m_hold));
    end
    model(r, bt, tgt, pl, il, rdy, rd);
    m_known = 1'b1;
    @(posedge clock);
    #1;
    check("if_id_pc", if_id_pc, m_ipc);
    check("if_id_instr", 64'(if_id_instr), 64'(m_instr));
    check("if_id_valid", 64'(if_id_valid), 64'(m_valid));
`ifdef FETCH_STALL_CNT_EN
    check("stall_count", 64'(stall_count), 64'(m_cnt));
`endif
  endtask
  initial begin
    logic [31:0] w;
    logic [31:0] w2;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] c0;
`endif
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_addr", imem.addr, 64'h0);
    check("rst_req", 64'(imem.req), 64'h1);
    check("rst_instr", 64'(if_id_instr), 64'h13);
    check("rst_valid", 64'(if_id_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 1, 1, 32'hA0000000 + 32'(i));
      check("seq_addr", imem.addr, 64'(4 * (i + 1)));
      check("seq_if_pc", if_id_pc, 64'(4 * i));
      check("seq_valid", 64'(if_id_valid), 64'h1);
    end
    w = $urandom();
    step(0, 0, 0, 0, 0, 1, w);
    for (int i = 0; i < 3; i++) begin
      check("hold_req", 64'(imem.req), 64'h0);
      check("hold_if_pc", if_id_pc, 64'hC);
      step(0, 0, 0, 0, 0, 1, $urandom());
    end
    step(0, 0, 0, 1, 1, 0, 0);
    check("hold_instr", 64'(if_id_instr), 64'(w));
    check("hold_if_pc2", if_id_pc, 64'h10);
    check("hold_next", imem.addr, 64'h14);
`ifdef FETCH_STALL_CNT_EN
    c0 = stall_count;
`endif
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    check("bub_valid", 64'(if_id_valid), 64'h0);
    check("bub_addr", imem.addr, 64'h14);
`ifdef FETCH_STALL_CNT_EN
    check("bub_cnt", 64'(stall_count - c0), 64'h2);
`endif
    step(0, 0, 0, 0, 1, 1, $urandom());
    step(0, 1, 64'h203, 0, 0, 1, $urandom());
    check("br_addr", imem.addr, 64'h200);
    check("br_instr", 64'(if_id_instr), 64'h13);
    check("br_valid", 64'(if_id_valid), 64'h0);
    w2 = $urandom();
    step(0, 0, 0, 1, 1, 1, w2);
    check("br_fresh", 64'(if_id_instr), 64'(w2));
    check("br_fresh_pc", if_id_pc, 64'h200);
    step(0, 1, 64'hFFFFFFFFFFFFFFFC, 1, 1, 1, $urandom());
    step(0, 0, 0, 1, 1, 1, $urandom());
    check("wrap_addr", imem.addr, 64'h0);
    check("wrap_if_pc", if_id_pc, 64'hFFFFFFFFFFFFFFFC);
    step(0, 0, 0, 1, 0, 1, $urandom());
    step(1, 0, 0, 0, 0, 0, 0);
    check("rhold_addr", imem.addr, 64'h0);
    check("rhold_req", 64'(imem.req), 64'h1);
    w2 = $urandom();
    step(0, 0, 0, 1, 1, 1, w2);
    check("rhold_instr", 64'(if_id_instr), 64'(w2));
    step(1, 1, 64'h500, 1, 1, 1, $urandom());
    check("rbr_addr", imem.addr, 64'h0);
    check("rbr_valid", 64'(if_id_valid), 64'h0);
    check("rbr_req", 64'(imem.req), 64'h1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, {$urandom(), $urandom()},
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
